// File: rtl/axis_packet_fifo_replay.sv
// Purpose : AXI-Stream packet FIFO whose read side can rewind and replay the packet being output.
// Latency : cut-through 2 cycles write->out; store-and-forward 2 cycles after the tlast write.
// Backpres: axis_i_tready drops when the buffer is full; space is freed only on an output tlast handshake.
//
// Ports:
//   clk, sreset                      single clock, synchronous active-high reset
//   axis_i_*  (tvalid/tready/tdata/tuser/tkeep/tlast)   input stream
//   axis_o_*  (tvalid/tready/tdata/tuser/tkeep/tlast)   output stream, beats unmodified
//   axis_o_rewind                    one-cycle request to restart the current output packet
//
// Build option: define AXIS_PACKET_FIFO_REPLAY_STORE_FORWARD_EN to release a packet only after its
// tlast beat is written; without it the FIFO runs cut-through.
// Packets longer than 2**LOG2_DEPTH beats deadlock (storage is freed per packet) and are not detected.
module axis_packet_fifo_replay #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int LOG2_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      sreset,
    input  logic                      axis_i_tvalid,
    output logic                      axis_i_tready,
    input  logic [8*AXIS_BYTES-1:0]   axis_i_tdata,
    input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
    input  logic [AXIS_BYTES-1:0]     axis_i_tkeep,
    input  logic                      axis_i_tlast,
    output logic                      axis_o_tvalid,
    input  logic                      axis_o_tready,
    output logic [8*AXIS_BYTES-1:0]   axis_o_tdata,
    output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
    output logic [AXIS_BYTES-1:0]     axis_o_tkeep,
    output logic                      axis_o_tlast,
    input  logic                      axis_o_rewind
);

    localparam int DW    = 8 * AXIS_BYTES;
    localparam int EW    = 1 + DW + AXIS_USER_BITS + AXIS_BYTES;
    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int PW    = LOG2_DEPTH + 1;
    localparam logic [PW-1:0] PTR_ONE = {{LOG2_DEPTH{1'b0}}, 1'b1};

    // Storage and registered read port (the read register is the output beat).
    logic [EW-1:0] r_mem [DEPTH];
    logic [EW-1:0] r_out_dat;
    logic          r_out_vld;

    // Pointers carry an extra MSB as wrap flag.
    logic [PW-1:0] r_wrptr;
    logic [PW-1:0] r_rdptr;
    logic [PW-1:0] r_outptr;
    logic [PW-1:0] r_crdptr;

    logic          w_full;
    logic          w_wr;
    logic          w_out_hs;
    logic          w_commit;
    logic          w_fetch;
    logic [PW-1:0] w_limit;
    logic [EW-1:0] w_wr_dat;

    // Full is measured against the committed read pointer: beats already shown
    // downstream still occupy space until their packet completes.
    assign w_full   = (r_wrptr[LOG2_DEPTH-1:0] == r_crdptr[LOG2_DEPTH-1:0]) &&
                      (r_wrptr[LOG2_DEPTH] != r_crdptr[LOG2_DEPTH]);
    assign axis_i_tready = !w_full && !sreset;
    assign w_wr     = axis_i_tvalid && axis_i_tready;
    assign w_wr_dat = {axis_i_tlast, axis_i_tdata, axis_i_tuser, axis_i_tkeep};

`ifdef AXIS_PACKET_FIFO_REPLAY_STORE_FORWARD_EN
    // Write pointer just past the last complete packet; reads never pass it.
    logic [PW-1:0] r_cwrptr;

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_cwrptr <= '0;
        end else if (w_wr && axis_i_tlast) begin
            r_cwrptr <= r_wrptr + PTR_ONE;
        end
    end

    assign w_limit = r_cwrptr;
`else
    assign w_limit = r_wrptr;
`endif

    assign w_out_hs = r_out_vld && axis_o_tready;
    assign w_commit = w_out_hs && axis_o_tlast;
    // Rewind suppresses the fetch so the output register can reload from crdptr.
    assign w_fetch  = (r_rdptr != w_limit) && (!r_out_vld || axis_o_tready) && !axis_o_rewind;

    assign axis_o_tvalid = r_out_vld;
    assign {axis_o_tlast, axis_o_tdata, axis_o_tuser, axis_o_tkeep} = r_out_dat;

    // Simple dual-port RAM, no reset on contents. A fetch never reads the slot
    // being written: rdptr only trails wrptr, and writes stop when full.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wrptr[LOG2_DEPTH-1:0]] <= w_wr_dat;
        end
        if (w_fetch) begin
            r_out_dat <= r_mem[r_rdptr[LOG2_DEPTH-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            r_wrptr   <= '0;
            r_rdptr   <= '0;
            r_outptr  <= '0;
            r_crdptr  <= '0;
            r_out_vld <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wrptr <= r_wrptr + PTR_ONE;
            end
            if (w_commit) begin
                r_crdptr <= r_outptr;
            end
            if (axis_o_rewind) begin
                // A packet finishing in the same cycle stays finished; otherwise
                // restart from the first beat of the current packet.
                r_rdptr   <= w_commit ? r_outptr : r_crdptr;
                r_out_vld <= 1'b0;
            end else if (w_fetch) begin
                r_rdptr   <= r_rdptr + PTR_ONE;
                r_outptr  <= r_rdptr + PTR_ONE;
                r_out_vld <= 1'b1;
            end else if (w_out_hs) begin
                r_out_vld <= 1'b0;
            end
        end
    end

endmodule
